// File: rtl/mem512_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared 512x32 memory.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface mem512_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic              mem_wEn;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output ack0, ack1, rdata0, rdata1, busy, mem_wEn, mem_addr, mem_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  ack0, ack1, rdata0, rdata1, busy, mem_wEn, mem_addr, mem_din
    );
endinterface

// File: rtl/mem512_arbiter.sv
// Round-robin arbiter sharing one single-port 512x32 memory between a fetch port (0)
// and a load/store port (1); one access every three cycles (IDLE -> ACCESS -> RESP).
module mem512_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem512_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_prio;
    logic              r_sel;
    logic              r_we_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_wdata_q;

    logic [1:0]        w_req;
    logic [1:0]        w_we;
    logic [ADDR_W-1:0] w_addr  [2];
    logic [DATA_W-1:0] w_wdata [2];
    logic [1:0]        w_ack;
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_any_req;
    logic              w_grant;
    logic              w_busy;
    logic              w_mem_wen;

    assign w_req      = {bus.req1, bus.req0};
    assign w_we       = {bus.we1, bus.we0};
    assign w_addr[0]  = bus.addr0;
    assign w_addr[1]  = bus.addr1;
    assign w_wdata[0] = bus.wdata0;
    assign w_wdata[1] = bus.wdata1;

    // A lone requester always wins; on contention the pointer decides.
    assign w_any_req = |w_req;
    assign w_grant   = (&w_req) ? r_prio : w_req[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = w_any_req ? ACCESS : IDLE;
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Reset gates the write enable combinationally so an interrupted access never commits.
    always_comb begin
        w_busy    = (r_state != IDLE);
        w_mem_wen = (r_state == ACCESS) & r_we_q & ~rst;
    end

    assign bus.busy     = w_busy;
    assign bus.mem_wEn  = w_mem_wen;
    assign bus.mem_addr = r_addr_q;
    assign bus.mem_din  = r_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_sel     <= 1'b0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
        end else if (r_state == IDLE && w_any_req) begin
            r_sel     <= w_grant;
            r_prio    <= ~w_grant;
            r_we_q    <= w_we[w_grant];
            r_addr_q  <= w_addr[w_grant];
            r_wdata_q <= w_wdata[w_grant];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT = 1'(gi);
            logic              r_ack;
            logic [DATA_W-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                end else begin
                    r_ack <= (r_state == ACCESS) && (r_sel == PORT);
                    if (r_state == ACCESS && r_sel == PORT && !r_we_q) begin
                        r_rdata <= bus.mem_dout;
                    end
                end
            end

            assign w_ack[gi]   = r_ack;
            assign w_rdata[gi] = r_rdata;
        end
    endgenerate

    assign bus.ack0   = w_ack[0];
    assign bus.ack1   = w_ack[1];
    assign bus.rdata0 = w_rdata[0];
    assign bus.rdata1 = w_rdata[1];
endmodule

// File: doc/mem512_arbiter.md
# mem512_arbiter

Two-requester round-robin arbiter that shares one 512×32 single-port data memory (synchronous write, combinational read: `dout` follows `addr` within the cycle) between an instruction-fetch master (port 0) and a load/store master (port 1). It accepts one request at a time, drives the memory's `wEn`/`addr`/`din` from registered copies of the winning request, captures read data, and returns a one-cycle acknowledge. It sits between the CPU's fetch/LSU front ends and the memory instance.

## Interface
- `ADDR_W`, 9, memory address width (512 words)
- `DATA_W`, 32, memory data width

- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous, active-high reset
- `req0`, `req1` in 1, request from port 0 / port 1; held until that port's ack
- `we0`, `we1` in 1, 1 = write, 0 = read; stable while req high
- `addr0`, `addr1` in ADDR_W, word address
- `wdata0`, `wdata1` in DATA_W, write data
- `ack0`, `ack1` out 1, one-cycle completion pulse
- `rdata0`, `rdata1` out DATA_W, registered read data; valid while the matching ack is high, held until the next read by that port
- `busy` out 1, high in ACCESS and RESP
- `mem_wEn` out 1, to memory `wEn`
- `mem_addr` out ADDR_W, to memory `addr`
- `mem_din` out DATA_W, to memory `din`
- `mem_dout` in DATA_W, from memory `dout`

## Operation
- FSM states: IDLE, ACCESS, RESP. Each access takes exactly 3 cycles; no pipelining.
- IDLE: requests are sampled only here. At an edge with any req high, latch winner index `sel`, its `we`, `addr`, and `wdata` into `we_q`/`addr_q`/`wdata_q`, then go to ACCESS. With no request, stay in IDLE.
- Arbitration is round-robin with a 1-bit priority pointer `prio`, reset to 0.
  - Only one req high: that port wins, whatever `prio` is.
  - Both high: port `prio` wins.
  - After every grant, `prio` becomes the other port (`~sel`).
- ACCESS:
  - `mem_addr = addr_q` and `mem_din = wdata_q`.
  - `mem_wEn = we_q & ~rst`, combinational, so reset in this cycle suppresses the write.
  - At the closing edge:
    - On a read, `rdata[sel] <= mem_dout`.
    - Assert `ack[sel]`.
    - Go to RESP.
- RESP: `ack[sel]` is high for this one cycle. The requester drops or changes req at the edge ending RESP. Next state is IDLE. Requests are ignored in RESP.
- Writes leave `rdata` unchanged. The other port's `rdata` is never touched.
- `mem_addr` and `mem_din` hold their last latched values outside ACCESS. `mem_wEn` is 0 outside ACCESS.
- A req that drops before its grant is simply not served; no error is flagged.

## Timing
- Reset (any state): next state IDLE.
  - Zeroed outputs/registers: `prio`, `sel`, `we_q`, `addr_q`, `wdata_q`, `ack0`, `ack1`, `rdata0`, `rdata1`, `busy`, `mem_wEn`, `mem_addr`, `mem_din`.
  - An access interrupted by reset produces no memory write and no ack.
- Latency, with req sampled high at edge E0 (state IDLE):
  - Cycle E0→E1: ACCESS; memory write commits at E1.
  - Cycle E1→E2: RESP; `ack` and `rdata` valid.
  - E2: back in IDLE; the next request can be sampled at E2 earliest.
- Sustained throughput: one access per 3 cycles. Under continuous requests from both ports, grants alternate 0,1,0,1…
- Read-after-write to the same address by either port returns the new data, because the write commits before the next ACCESS.
- `ack0` and `ack1` are never high together. At most one ack occurs per 3 cycles.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, all req low for 5 cycles -> all outputs 0, `mem_wEn` never 1, `busy` 0.
- Single write/read on port 0:
  - Write `addr0`=200, `wdata0`=32'hDEADBEEF -> `mem_wEn`=1 for exactly one cycle with `mem_addr`=200, then `ack0` pulses 2 cycles after sampling.
  - Then read 200 -> `rdata0`=32'hDEADBEEF during `ack0`; `rdata1` stays 0.
- Simultaneous requests after reset:
  - Both read (port 0 addr 200, port 1 addr 201 previously written 32'h12345678) -> port 0 served first (`ack0` at cycle 2), port 1 next (`ack1` at cycle 5, `rdata1`=32'h12345678).
  - Repeat both -> the order continues alternating 0,1,0,1.
- Fairness under saturation: both ports hold req continuously for 12 cycles, each re-requesting after its ack -> exactly 2 `ack0` and 2 `ack1`, alternating, never overlapping.
- Reset mid-access: port 1 writes 32'hCAFEF00D to addr 300; assert `rst` during the ACCESS cycle -> no write. A later read of 300 returns the prior value; no ack was issued; `prio`=0.
- Port-1 write then port-0 read of the same address 511 in back-to-back requests -> `rdata0`=new data, confirming address wrap at the top entry (511) is handled without aliasing to 0.
